fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side pointer/flag controller of the async FIFO, entirely in the w_clk domain.
//  Directly upstream of the FIFO storage array: drives its waddr and wfull.
//  Syncs the read domain's Gray pointer, generates full/almost-full/level/overflow.
//  Exports its own Gray write pointer to the read-side controller.
// PARAMETERS
//  ADDR_SIZE    3  storage address width; depth = 2**ADDR_SIZE
//  SYNC_STAGES  2  flops in r_ptr_gray synchronizer (>=2)
//  AFULL_THRESH 6  w_afull asserts when level >= this value (1..2**ADDR_SIZE)
// PORTS
//  w_clk       in   1            write-domain clock
//  w_rst       in   1            async reset, active-low
//  w_inc       in   1            write request; accepted iff !wfull
//  ovf_clr     in   1            clears sticky w_ovf
//  r_ptr_gray  in   ADDR_SIZE+1  read Gray pointer (read domain, asynchronous)
//  waddr       out  ADDR_SIZE    storage write address
//  w_ptr_gray  out  ADDR_SIZE+1  registered Gray write pointer, to read domain
//  wfull       out  1            FIFO full; storage ignores writes while high
//  w_afull     out  1            level >= AFULL_THRESH
//  w_level     out  ADDR_SIZE+1  occupancy estimate (0..2**ADDR_SIZE)
//  w_ovf       out  1            sticky: write attempted while full
// BEHAVIOUR
//  Clock and reset: one clock (w_clk); reset (w_rst) asynchronous, active-low.
//  Reset: every register 0, sync chain included.
//   Outputs: waddr=0, w_ptr_gray=0, wfull=0, w_afull=0, w_level=0, w_ovf=0.
//  Pointer:
//   - wbin is an (ADDR_SIZE+1)-bit binary register.
//   - wbin_nxt = wbin + (w_inc & ~wfull), modulo 2**(ADDR_SIZE+1).
//   - waddr = wbin[ADDR_SIZE-1:0].
//   - w_ptr_gray is registered as gray(wbin_nxt) = wbin_nxt ^ (wbin_nxt>>1).
//   - Only one bit of w_ptr_gray changes per edge; it drives no combinational output.
//  Sync:
//   - r_ptr_gray passes through SYNC_STAGES flops to give rq_sync.
//   - rbin_sync = gray2bin(rq_sync), a combinational XOR-prefix of rq_sync.
//   - No other logic samples r_ptr_gray.
//  Full (registered, updated on every edge):
//   - wfull <= (gray(wbin_nxt) == {~rq_sync[A:A-1], rq_sync[A-2:0]}), where A = ADDR_SIZE.
//   - The write that fills the FIFO raises wfull on the same edge that
//     accepts it; the next cycle already blocks.
//   - wfull deassertion lags a read by SYNC_STAGES+1 w_clk edges.
//     This is pessimistic and never loses data.
//  Level:
//   - w_level <= wbin_nxt - rbin_sync, modulo 2**(ADDR_SIZE+1).
//   - Value 2**ADDR_SIZE exactly when wfull is high.
//   - w_afull <= (wbin_nxt - rbin_sync) >= AFULL_THRESH, registered with w_level.
//  Overflow:
//   - w_inc & wfull sets w_ovf on the next edge; the pointer does not move.
//   - ovf_clr clears w_ovf; a same-cycle set wins over the clear.
//  Wrap: wbin rolls from 2**(ADDR_SIZE+1)-1 to 0; full, level and afull stay correct across the wrap.
//  Simultaneous: w_inc while the synced read pointer advances uses the
//   current rq_sync; the level settles to the exact value.
//  Reset mid-operation:
//   - Immediate return to reset values; an in-flight write is dropped.
//   - The read domain must be reset in the same window.
// TESTING (ADDR_SIZE=3, SYNC_STAGES=2, AFULL_THRESH=6)
//  1 Reset:
//     - Assert w_rst low mid-cycle -> all outputs 0 asynchronously, before any edge.
//  2 Fill:
//     - r_ptr_gray=0, 8 back-to-back w_inc -> waddr 0..7.
//     - w_afull=1 after the 6th edge.
//     - wfull=1 and w_level=8 after the 8th edge; w_ptr_gray=4'b1100.
//  3 Overflow:
//     - 9th w_inc while full -> waddr stays 0, w_ptr_gray unchanged, w_ovf=1.
//     - ovf_clr with w_inc still high -> w_ovf stays 1.
//     - ovf_clr alone -> w_ovf=0.
//  4 Drain visibility:
//     - From full, set r_ptr_gray=4'b0010 (rbin 3) -> wfull=0 and w_level=5
//       exactly 3 edges later; w_afull=0.
//  5 Wrap:
//     - Cycle 20 writes with r_ptr_gray tracking 2 behind.
//     - Expect wbin 15->0 with gray 4'b1000->4'b0000.
//     - Expect w_level=2, wfull never set.
//  6 Gray check:
//     - Over random w_inc, assert w_ptr_gray has Hamming distance <=1 per edge.
//     - Assert no write is accepted while wfull.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle between the async FIFO write controller and its user.
// Ports: w_inc/ovf_clr/r_ptr_gray toward the controller; waddr, w_ptr_gray,
//        wfull, w_afull, w_level, w_ovf back from it.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_SIZE = 3
);
  logic                 w_inc;
  logic                 ovf_clr;
  logic [ADDR_SIZE:0]   r_ptr_gray;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   w_ptr_gray;
  logic                 wfull;
  logic                 w_afull;
  logic [ADDR_SIZE:0]   w_level;
  logic                 w_ovf;

  // Writer / environment side.
  modport master (
    output w_inc, ovf_clr, r_ptr_gray,
    input  waddr, w_ptr_gray, wfull, w_afull, w_level, w_ovf
  );

  // Controller side.
  modport slave (
    input  w_inc, ovf_clr, r_ptr_gray,
    output waddr, w_ptr_gray, wfull, w_afull, w_level, w_ovf
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller of an async FIFO (w_clk domain only).
// Latency: an accepted write moves waddr/w_ptr_gray/flags on the same edge; a read becomes visible after SYNC_STAGES+1 edges.
// Backpressure: wfull blocks w_inc (pointer holds, sticky w_ovf set); full release is pessimistic, never lossy.
// Ports: w_clk, w_rst (async, active-low), bus (slave): w_inc, ovf_clr, r_ptr_gray in;
//        waddr, w_ptr_gray, wfull, w_afull, w_level, w_ovf out.
module fifo_wr_ctrl #(
  parameter int ADDR_SIZE    = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic           w_clk,
  input  logic           w_rst,
  fifo_wr_ctrl_if.slave  bus
);
  localparam int A = ADDR_SIZE;
  localparam logic [A:0] AFULL_T = AFULL_THRESH[A:0];

  logic [A:0] wbin_q,  wbin_d;
  logic [A:0] wgray_q, wgray_d;
  logic [A:0] rq_q [SYNC_STAGES];
  logic [A:0] rq_d [SYNC_STAGES];
  logic       wfull_q, wfull_d;
  logic       wafull_q, wafull_d;
  logic [A:0] wlevel_q, wlevel_d;
  logic       wovf_q, wovf_d;

  logic [A:0] rq_sync;
  logic [A:0] rbin_sync;
  logic       accept;

  // Synchronizer for the read-domain Gray pointer; nothing else touches r_ptr_gray.
  always_comb begin
    rq_d[0] = bus.r_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      rq_d[i] = rq_q[i-1];
    end
  end

  assign rq_sync = rq_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i <= A; i++) begin
      rbin_sync[i] = ^(rq_sync >> i);
    end
  end

  always_comb begin
    accept   = bus.w_inc & ~wfull_q;
    wbin_d   = wbin_q + {{A{1'b0}}, accept};
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    // Full when the next write pointer has lapped the read pointer exactly once:
    // in Gray code that means the two MSBs differ and the rest match.
    wfull_d  = (wgray_d == {~rq_sync[A:A-1], rq_sync[A-2:0]});
    wlevel_d = wbin_d - rbin_sync;
    wafull_d = (wlevel_d >= AFULL_T);
    // A set in the same cycle as a clear wins so no overflow event is lost.
    wovf_d   = (bus.w_inc & wfull_q) | (wovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rq_q[i] <= '0;
      end
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wlevel_q <= wlevel_d;
      wovf_q   <= wovf_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rq_q[i] <= rq_d[i];
      end
    end
  end

  assign bus.waddr      = wbin_q[A-1:0];
  assign bus.w_ptr_gray = wgray_q;
  assign bus.wfull      = wfull_q;
  assign bus.w_afull    = wafull_q;
  assign bus.w_level    = wlevel_q;
  assign bus.w_ovf      = wovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl (ADDR_SIZE=3, SYNC_STAGES=2, AFULL_THRESH=6).
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: fill/overflow/drain via vector table, then wrap and random Gray/full-block sequences.
module tb_fifo_wr_ctrl;
  logic w_clk = 1'b0;
  logic w_rst = 1'b0;

  fifo_wr_ctrl_if #(.ADDR_SIZE(3)) bus ();

  fifo_wr_ctrl #(.ADDR_SIZE(3), .SYNC_STAGES(2), .AFULL_THRESH(6)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus.slave)
  );

  always #5 w_clk = ~w_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_eq(input string nm, input int act, input int exp);
    chk(nm, act == exp, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, " waddr"},      int'(bus.waddr),      0);
    chk_eq({tag, " w_ptr_gray"}, int'(bus.w_ptr_gray), 0);
    chk_eq({tag, " wfull"},      int'(bus.wfull),      0);
    chk_eq({tag, " w_afull"},    int'(bus.w_afull),    0);
    chk_eq({tag, " w_level"},    int'(bus.w_level),    0);
    chk_eq({tag, " w_ovf"},      int'(bus.w_ovf),      0);
  endtask

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  typedef struct {
    logic       w_inc;
    logic       ovf_clr;
    logic [3:0] r_gray;
    logic [2:0] e_waddr;
    logic [3:0] e_gray;
    logic       e_full;
    logic       e_afull;
    logic [3:0] e_level;
    logic       e_ovf;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  initial begin
    logic [3:0] wcnt;
    logic [3:0] rcnt;
    logic [3:0] prev_gray;
    logic [2:0] prev_waddr;
    logic       pre_full;
    logic       pre_inc;

    // Expected state after each edge.
    //             inc clr r_gray   waddr gray     full afull level ovf
    vt[0]  = '{1'b1, 1'b0, 4'b0000, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 4'b0000, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 4'b0000, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 4'b0000, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 4'b0000, 3'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 4'b0000, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 4'b0000, 3'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 4'b0000, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
    // Overflow: pointer frozen, sticky flag, set beats clear.
    vt[8]  = '{1'b1, 1'b0, 4'b0000, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 4'b0000, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
    vt[10] = '{1'b0, 1'b1, 4'b0000, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
    // Reader reaches 3: visible on the third edge.
    vt[11] = '{1'b0, 1'b0, 4'b0010, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
    vt[12] = '{1'b0, 1'b0, 4'b0010, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
    vt[13] = '{1'b0, 1'b0, 4'b0010, 3'd0, 4'b1100, 1'b0, 1'b0, 4'd5, 1'b0};
    vt[14] = '{1'b1, 1'b0, 4'b0010, 3'd1, 4'b1101, 1'b0, 1'b1, 4'd6, 1'b0};

    bus.w_inc      = 1'b0;
    bus.ovf_clr    = 1'b0;
    bus.r_ptr_gray = '0;

    // Reset state.
    #1;
    chk_all_zero("reset");
    #20 w_rst = 1'b1;
    @(posedge w_clk); #1;
    chk_all_zero("idle");

    // Fill, overflow and drain vectors.
    for (int i = 0; i < NV; i++) begin
      bus.w_inc      = vt[i].w_inc;
      bus.ovf_clr    = vt[i].ovf_clr;
      bus.r_ptr_gray = vt[i].r_gray;
      @(posedge w_clk); #1;
      chk_eq($sformatf("v%0d waddr", i),      int'(bus.waddr),      int'(vt[i].e_waddr));
      chk_eq($sformatf("v%0d w_ptr_gray", i), int'(bus.w_ptr_gray), int'(vt[i].e_gray));
      chk_eq($sformatf("v%0d wfull", i),      int'(bus.wfull),      int'(vt[i].e_full));
      chk_eq($sformatf("v%0d w_afull", i),    int'(bus.w_afull),    int'(vt[i].e_afull));
      chk_eq($sformatf("v%0d w_level", i),    int'(bus.w_level),    int'(vt[i].e_level));
      chk_eq($sformatf("v%0d w_ovf", i),      int'(bus.w_ovf),      int'(vt[i].e_ovf));
    end

    // Mid-cycle asynchronous reset with a write in flight.
    bus.w_inc = 1'b1;
    #2 w_rst = 1'b0;
    #1;
    chk_all_zero("async reset");
    bus.w_inc = 1'b0;
    @(negedge w_clk);
    w_rst = 1'b1;

    // Wrap: 20 writes with the reader two behind.
    bus.w_inc = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      bus.r_ptr_gray = gray((i >= 3) ? 4'(i - 3) : 4'd0);
      @(posedge w_clk); #1;
      chk_eq($sformatf("wrap%0d wfull", i), int'(bus.wfull), 0);
      if (i == 15) chk_eq("wrap gray at wbin 15", int'(bus.w_ptr_gray), 4'b1000);
      if (i == 16) begin
        chk_eq("wrap gray at wbin 0", int'(bus.w_ptr_gray), 4'b0000);
        chk_eq("wrap waddr at wbin 0", int'(bus.waddr), 0);
      end
    end
    bus.w_inc      = 1'b0;
    bus.r_ptr_gray = 4'b0011;
    repeat (3) @(posedge w_clk);
    #1;
    chk_eq("wrap settled level", int'(bus.w_level), 2);
    chk_eq("wrap settled afull", int'(bus.w_afull), 0);
    chk_eq("wrap settled waddr", int'(bus.waddr),   4);

    // Random writes and reads: single-bit Gray steps, no write while full.
    wcnt = 4'd4;
    rcnt = 4'd2;
    for (int c = 0; c < 300; c++) begin
      bus.w_inc = ($urandom_range(0, 9) < 7);
      if (rcnt != wcnt && $urandom_range(0, 2) == 0) rcnt = rcnt + 4'd1;
      bus.r_ptr_gray = gray(rcnt);
      prev_gray  = bus.w_ptr_gray;
      prev_waddr = bus.waddr;
      pre_full   = bus.wfull;
      pre_inc    = bus.w_inc;
      @(posedge w_clk); #1;
      chk("gray hamming", $countones(prev_gray ^ bus.w_ptr_gray) <= 1,
          $countones(prev_gray ^ bus.w_ptr_gray), 1);
      if (pre_inc && pre_full)
        chk_eq("blocked while full", int'(bus.waddr), int'(prev_waddr));
      if (pre_inc && !pre_full) wcnt = wcnt + 4'd1;
      chk_eq("random waddr", int'(bus.waddr), int'(wcnt[2:0]));
      chk_eq("random gray",  int'(bus.w_ptr_gray), int'(gray(wcnt)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
